// File: rtl/qdr4_sram_model_if.sv
// rtl/qdr4_sram_model_if.sv - command, data and status bundle for both QDR-IV ports
interface qdr4_sram_model_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 36
) ();

  // port A
  logic              lda_n;
  logic              rwa_n;
  logic [ADDR_W-1:0] aa;
  logic              apa;
  logic [DATA_W-1:0] da;
  logic [DATA_W-1:0] qa;
  logic              qvlda;

  // port B
  logic              ldb_n;
  logic              rwb_n;
  logic [ADDR_W-1:0] ab;
  logic              apb;
  logic [DATA_W-1:0] db;
  logic [DATA_W-1:0] qb;
  logic              qvldb;

  // shared
  logic              ainv;
  logic              pe_n;

  // memory controller side
  modport master (
    output lda_n, rwa_n, aa, apa, da,
    output ldb_n, rwb_n, ab, apb, db,
    output ainv,
    input  qa, qvlda, qb, qvldb, pe_n
  );

  // SRAM side
  modport slave (
    input  lda_n, rwa_n, aa, apa, da,
    input  ldb_n, rwb_n, ab, apb, db,
    input  ainv,
    output qa, qvlda, qb, qvldb, pe_n
  );

endinterface

// File: rtl/qdr4_sram_model.sv
// rtl/qdr4_sram_model.sv - two-port burst-2 QDR-IV x36 SRAM model with fixed read/write latency
module qdr4_sram_model #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 36,
  parameter int RL        = 8,
  parameter int WL        = 5,
  parameter int PARITY_EN = 1
) (
  input  logic                    i_k,
  input  logic                    i_rst,
  qdr4_sram_model_if.slave        bus
);

  localparam int WORD_W = 2 * DATA_W;
  localparam int DEPTH  = 1 << ADDR_W;

  // Index 0 is port A, index 1 is port B throughout.
  logic [1:0]        w_ld_n;
  logic [1:0]        w_rw_n;
  logic [1:0]        w_ap;
  logic [1:0]        w_par_ok;
  logic [1:0]        w_cmd;
  logic [1:0]        w_acc;
  logic              w_perr;
  logic [ADDR_W-1:0] w_a    [2];
  logic [ADDR_W-1:0] w_addr [2];
  logic [DATA_W-1:0] w_d    [2];

  logic [1:0]        r_busy;
  logic [1:0]        r_qv;
  logic              r_pe_n;
  logic [DATA_W-1:0] r_q     [2];
  logic [DATA_W-1:0] r_beat0 [2];

  // Valid shift registers: bit j set means the command was accepted j+1 edges ago.
  logic [WL:0]       r_wv [2];
  logic [RL:0]       r_rv [2];

  // Address and read-word pipelines travel alongside the valid bits.
  logic [ADDR_W-1:0] r_wa [2][WL+1];
  logic [WORD_W-1:0] r_rd [2][RL+1];

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Decode the per-port command: address inversion, parity and the busy gate.
  always_comb begin
    w_ld_n = {bus.ldb_n, bus.lda_n};
    w_rw_n = {bus.rwb_n, bus.rwa_n};
    w_ap   = {bus.apb, bus.apa};
    w_a[0] = bus.aa;
    w_a[1] = bus.ab;
    w_d[0] = bus.da;
    w_d[1] = bus.db;
    w_par_ok = '0;
    w_cmd    = '0;
    w_acc    = '0;
    for (int p = 0; p < 2; p++) begin
      // parity is judged on the pins as received, before any inversion
      w_addr[p]   = bus.ainv ? ~w_a[p] : w_a[p];
      w_par_ok[p] = (PARITY_EN == 0) || ((^w_a[p]) == w_ap[p]);
      w_cmd[p]    = ~w_ld_n[p] & ~r_busy[p] & ~i_rst;
      w_acc[p]    = w_cmd[p] & w_par_ok[p];
    end
    // a command swallowed by the busy cycle never reaches the parity checker
    w_perr = |(w_cmd & ~w_par_ok);
  end

  // Control state: busy flags, valid pipelines, read output beats and the sticky parity flag.
  always_ff @(posedge i_k) begin
    if (i_rst) begin
      r_busy <= '0;
      r_qv   <= '0;
      r_pe_n <= 1'b1;
      for (int p = 0; p < 2; p++) begin
        r_wv[p] <= '0;
        r_rv[p] <= '0;
        r_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        r_busy[p] <= w_acc[p];
        r_wv[p]   <= {r_wv[p][WL-1:0], w_acc[p] & ~w_rw_n[p]};
        r_rv[p]   <= {r_rv[p][RL-1:0], w_acc[p] &  w_rw_n[p]};
        // Two-cycle spacing guarantees beat0 and beat1 of different reads never overlap.
        if (r_rv[p][RL-1]) begin
          r_q[p]  <= r_rd[p][RL-1][DATA_W-1:0];
          r_qv[p] <= 1'b1;
        end else if (r_rv[p][RL]) begin
          r_q[p]  <= r_rd[p][RL][WORD_W-1:DATA_W];
          r_qv[p] <= 1'b1;
        end else begin
          r_q[p]  <= '0;
          r_qv[p] <= 1'b0;
        end
      end
      if (w_perr) begin
        r_pe_n <= 1'b0;
      end
    end
  end

  // Datapath pipelines: write addresses, beat0 capture and the read word snapshot.
  always_ff @(posedge i_k) begin
    for (int p = 0; p < 2; p++) begin
      r_wa[p][0] <= w_addr[p];
      for (int j = 1; j <= WL; j++) begin
        r_wa[p][j] <= r_wa[p][j-1];
      end
      // snapshot taken on the command edge, so a write committing on that edge is not seen
      r_rd[p][0] <= r_mem[w_addr[p]];
      for (int j = 1; j <= RL; j++) begin
        r_rd[p][j] <= r_rd[p][j-1];
      end
      if (r_wv[p][WL-1]) begin
        r_beat0[p] <= w_d[p];
      end
    end
  end

  // Array commit with beat1 taken live; port B is written last so it wins a same-address collision.
  always_ff @(posedge i_k) begin
    if (!i_rst) begin
      for (int p = 0; p < 2; p++) begin
        if (r_wv[p][WL]) begin
          r_mem[r_wa[p][WL]] <= {w_d[p], r_beat0[p]};
        end
      end
    end
  end

  assign bus.qa    = r_q[0];
  assign bus.qb    = r_q[1];
  assign bus.qvlda = r_qv[0];
  assign bus.qvldb = r_qv[1];
  assign bus.pe_n  = r_pe_n;

endmodule

// File: tb/tb_qdr4_sram_model.sv
// tb/tb_qdr4_sram_model.sv - randomized and directed bench with a cycle-indexed behavioural model
module tb_qdr4_sram_model;

  localparam int RL   = 8;
  localparam int WL   = 5;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ec  = 0;

  int n_total = 0;
  int n_pass  = 0;

  qdr4_sram_model_if #(.ADDR_W(10), .DATA_W(36)) bus ();

  qdr4_sram_model #(
    .ADDR_W(10), .DATA_W(36), .RL(RL), .WL(WL), .PARITY_EN(1)
  ) dut (
    .i_k  (clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ec = ec + 1;

  // Model state, all indexed by rising-edge number.
  logic [71:0] m_mem [int];
  bit          m_pe = 1'b1;
  int          last_acc [2] = '{-10, -10};
  logic [35:0] d_hist [2][MAXE];
  bit          cm_v   [2][MAXE];
  int          cm_a   [2][MAXE];
  bit          exp_v  [2][MAXE];
  bit          exp_k  [2][MAXE];
  logic [35:0] exp_q  [2][MAXE];
  bit          exp_pe [MAXE];

  task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %h expected %h", nm, ec, act, exp);
  endtask

  // What edge e does, given the inputs currently on the pins.
  task automatic model_edge(int e);
    bit          ld [2];
    bit          rw [2];
    bit          ap [2];
    logic [9:0]  ra [2];
    logic [9:0]  ea;
    logic [71:0] w;
    bit          known;
    d_hist[0][e] = bus.da;
    d_hist[1][e] = bus.db;
    if (rst) begin
      m_pe = 1'b1;
      last_acc = '{-10, -10};
      for (int k = e; k < MAXE; k++) begin
        for (int p = 0; p < 2; p++) begin
          exp_v[p][k] = 1'b0;
          cm_v[p][k]  = 1'b0;
        end
      end
      exp_pe[e] = 1'b1;
      return;
    end
    ld[0] = bus.lda_n; rw[0] = bus.rwa_n; ap[0] = bus.apa; ra[0] = bus.aa;
    ld[1] = bus.ldb_n; rw[1] = bus.rwb_n; ap[1] = bus.apb; ra[1] = bus.ab;
    for (int p = 0; p < 2; p++) begin
      if (!ld[p] && last_acc[p] != e - 1) begin
        if ((^ra[p]) != ap[p]) begin
          m_pe = 1'b0;
        end else begin
          last_acc[p] = e;
          ea = bus.ainv ? ~ra[p] : ra[p];
          if (rw[p]) begin
            known = m_mem.exists(int'(ea));
            w = known ? m_mem[int'(ea)] : 72'd0;
            exp_v[p][e+RL]   = 1'b1; exp_k[p][e+RL]   = known; exp_q[p][e+RL]   = w[35:0];
            exp_v[p][e+RL+1] = 1'b1; exp_k[p][e+RL+1] = known; exp_q[p][e+RL+1] = w[71:36];
          end else begin
            cm_v[p][e+WL+1] = 1'b1;
            cm_a[p][e+WL+1] = int'(ea);
          end
        end
      end
    end
    exp_pe[e] = m_pe;
    // reads above saw the array before this edge's commits; B applied last wins collisions
    for (int p = 0; p < 2; p++) begin
      if (cm_v[p][e]) m_mem[cm_a[p][e]] = {d_hist[p][e], d_hist[p][e-1]};
    end
  endtask

  // Compare DUT outputs with the model after every edge.
  always @(negedge clk) begin
    if (ec >= 1 && ec < MAXE) begin
      chk("pe_n", 72'(bus.pe_n), 72'(exp_pe[ec]));
      chk("qvlda", 72'(bus.qvlda), 72'(exp_v[0][ec]));
      chk("qvldb", 72'(bus.qvldb), 72'(exp_v[1][ec]));
      if (exp_v[0][ec] && exp_k[0][ec]) chk("qa", 72'(bus.qa), 72'(exp_q[0][ec]));
      else if (!exp_v[0][ec])           chk("qa_idle", 72'(bus.qa), 72'd0);
      if (exp_v[1][ec] && exp_k[1][ec]) chk("qb", 72'(bus.qb), 72'(exp_q[1][ec]));
      else if (!exp_v[1][ec])           chk("qb_idle", 72'(bus.qb), 72'd0);
    end
  end

  task automatic cycle();
    model_edge(ec + 1);
    @(negedge clk);
  endtask

  task automatic step();
    cycle();
    bus.lda_n = 1'b1;
    bus.ldb_n = 1'b1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic set_cmd(int p, bit rd, logic [9:0] a, bit good);
    if (p == 0) begin
      bus.lda_n = 1'b0; bus.rwa_n = rd; bus.aa = a; bus.apa = good ? ^a : ~^a;
    end else begin
      bus.ldb_n = 1'b0; bus.rwb_n = rd; bus.ab = a; bus.apb = good ? ^a : ~^a;
    end
  endtask

  function automatic logic [9:0] pick_addr();
    logic [3:0] r;
    r = 4'($urandom_range(0, 15));
    return r[3] ? (10'h3F8 | 10'(r[2:0])) : 10'(r[2:0]);
  endfunction

  int cnt;

  initial begin
    bus.lda_n = 1'b1; bus.rwa_n = 1'b1; bus.aa = '0; bus.apa = 1'b0; bus.da = '0;
    bus.ldb_n = 1'b1; bus.rwb_n = 1'b1; bus.ab = '0; bus.apb = 1'b0; bus.db = '0;
    bus.ainv  = 1'b0;
    rst = 1'b1;
    cycle();
    cycle();
    chk("reset_qvlda", 72'(bus.qvlda), 72'd0);
    chk("reset_qa", 72'(bus.qa), 72'd0);
    chk("reset_pe_n", 72'(bus.pe_n), 72'd1);
    rst = 1'b0;
    idle(2);

    // write 0x005 then read it back on port A
    set_cmd(0, 1'b0, 10'h005, 1'b1); step();
    idle(4);
    bus.da = 36'h123456789; step();
    bus.da = 36'hABCDEF012; step();
    idle(3);
    set_cmd(0, 1'b1, 10'h005, 1'b1); step();
    idle(8);
    chk("t1_qvlda_b0", 72'(bus.qvlda), 72'd1);
    chk("t1_qa_b0", 72'(bus.qa), 72'h123456789);
    idle(1);
    chk("t1_qa_b1", 72'(bus.qa), 72'hABCDEF012);
    idle(1);
    chk("t1_qvlda_end", 72'(bus.qvlda), 72'd0);

    // port B read latency
    set_cmd(1, 1'b1, 10'h005, 1'b1); step();
    for (int i = 1; i <= 7; i++) begin
      idle(1);
      chk("lat_qvldb_low", 72'(bus.qvldb), 72'd0);
    end
    idle(1);
    chk("lat_qb_b0", {35'd0, bus.qvldb, bus.qb}, {35'd1, 36'h123456789});
    idle(1);
    chk("lat_qb_b1", {35'd0, bus.qvldb, bus.qb}, {35'd1, 36'hABCDEF012});
    idle(1);
    chk("lat_qvldb_after", 72'(bus.qvldb), 72'd0);

    // bad parity, then normal traffic, then reset restores the flag
    set_cmd(0, 1'b0, 10'h001, 1'b0); step();
    chk("par_pe_n_low", 72'(bus.pe_n), 72'd0);
    set_cmd(0, 1'b0, 10'h020, 1'b1); step();
    idle(4);
    bus.da = 36'h0AAAA0001; step();
    bus.da = 36'h0BBBB0002; step();
    idle(3);
    set_cmd(0, 1'b1, 10'h020, 1'b1); step();
    idle(8);
    chk("par_after_b0", 72'(bus.qa), 72'h0AAAA0001);
    idle(1);
    chk("par_after_b1", 72'(bus.qa), 72'h0BBBB0002);
    chk("par_pe_n_sticky", 72'(bus.pe_n), 72'd0);
    rst = 1'b1; step(); rst = 1'b0;
    chk("par_pe_n_reset", 72'(bus.pe_n), 72'd1);
    idle(2);

    // back-to-back commands: second is swallowed by the busy cycle
    set_cmd(0, 1'b1, 10'h005, 1'b1); step();
    set_cmd(0, 1'b1, 10'h005, 1'b1); step();
    cnt = 0;
    repeat (14) begin idle(1); cnt += int'(bus.qvlda); end
    chk("b2b_beats", 72'(cnt), 72'd2);

    // same-address collision, port B wins
    set_cmd(0, 1'b0, 10'h3FF, 1'b1);
    set_cmd(1, 1'b0, 10'h3FF, 1'b1); step();
    idle(4);
    bus.da = 36'h111; bus.db = 36'h333; step();
    bus.da = 36'h222; bus.db = 36'h444; step();
    idle(3);
    set_cmd(0, 1'b1, 10'h3FF, 1'b1); step();
    idle(8);
    chk("coll_b0", 72'(bus.qa), 72'h333);
    idle(1);
    chk("coll_b1", 72'(bus.qa), 72'h444);

    // reset mid-operation: read dropped, pending write discarded
    set_cmd(0, 1'b0, 10'h010, 1'b1); step();
    idle(4);
    bus.da = 36'hAAA; step();
    bus.da = 36'hBBB; step();
    idle(3);
    set_cmd(0, 1'b1, 10'h005, 1'b1);
    set_cmd(1, 1'b0, 10'h010, 1'b1); step();
    idle(2);
    rst = 1'b1; step(); rst = 1'b0;
    bus.da = 36'hDEAD0; bus.db = 36'hDEAD1;
    cnt = 0;
    repeat (12) begin idle(1); cnt += int'(bus.qvlda) + int'(bus.qvldb); end
    chk("rst_no_qvld", 72'(cnt), 72'd0);
    set_cmd(0, 1'b1, 10'h010, 1'b1); step();
    idle(8);
    chk("rst_old_b0", 72'(bus.qa), 72'hAAA);
    idle(1);
    chk("rst_old_b1", 72'(bus.qa), 72'hBBB);

    // address inversion: 0x3FA on the pins reaches word 0x005
    bus.ainv = 1'b1;
    set_cmd(0, 1'b1, 10'h3FA, 1'b1); step();
    bus.ainv = 1'b0;
    idle(8);
    chk("ainv_b0", 72'(bus.qa), 72'h123456789);
    idle(1);
    chk("ainv_b1", 72'(bus.qa), 72'hABCDEF012);
    idle(2);

    // randomized traffic on both ports
    repeat (2000) begin
      bus.da   = {4'($urandom), 32'($urandom)};
      bus.db   = {4'($urandom), 32'($urandom)};
      bus.ainv = ($urandom_range(0, 9) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 2) == 0)
          set_cmd(p, 1'($urandom_range(0, 1)), pick_addr(), $urandom_range(0, 19) != 0);
      end
      step();
    end
    rst = 1'b0;
    bus.ainv = 1'b0;
    idle(RL + 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/qdr4_sram_model.md
Name: qdr4_sram_model

Overview:
- Synthesizable single-clock, two-port, burst-2 model of a QDR-IV x36 SRAM for on-chip simulation and emulation of the external memory interface.
- Port A and port B each accept independent read/write commands.
- Each command moves two 36-bit beats, one per cycle, with fixed write and read latencies.
- Optional even address parity with a sticky error flag.

Parameters:
- ADDR_W, 10, word address width; depth = 2^ADDR_W entries of 2×DATA_W bits.
- DATA_W, 36, beat width.
- RL, 8, read latency: command edge to first read beat, in cycles, ≥2.
- WL, 5, write latency: command edge to first write beat, in cycles, ≥1.
- PARITY_EN, 1, enables address parity checking.

Ports:
- K  in  1  clock; everything is sampled on the rising edge.
- RST  in  1  synchronous, active-high reset.
- LDA_n  in  1  port A command valid, active low.
- RWA_n  in  1  port A: 1 = read, 0 = write.
- AA  in  ADDR_W  port A address.
- APA  in  1  port A address parity.
- DA  in  DATA_W  port A write data beats.
- QA  out  DATA_W  port A read data beats.
- QVLDA  out  1  QA valid.
- LDB_n, RWB_n, AB, APB, DB, QB, QVLDB: same as port A, for port B.
- AINV  in  1  when 1, both address inputs are bitwise inverted before use (parity is checked on the received, uninverted bits).
- PE_n  out  1  address parity error, active low, sticky.

Behaviour:
- Reset values: QA = QB = 0, QVLDA = QVLDB = 0, PE_n = 1; all pipelines flushed, busy flags cleared. Memory contents are not cleared (undefined after power-up).
- Command sampling: a port sees a command when LDx_n = 0 at a rising edge and the port is not busy.
- Busy rule: accepting a command makes the port busy for exactly the next cycle. A command in that busy cycle is ignored with no side effects. Commands therefore have a minimum spacing of 2 cycles per port.
- Parity (PARITY_EN = 1): a command is accepted only if XOR(Ax) ^ APx = 0. On a mismatch the command is dropped, does not set busy, and PE_n goes to 0 until RST.
- Write accepted at edge t:
  - DATA beat0 is sampled from Dx at edge t+WL, beat1 at edge t+WL+1.
  - The 2×DATA_W word {beat1, beat0} is written to the address at edge t+WL+1.
  - The address is pipelined with the command.
- Read accepted at edge t:
  - The array word is sampled at edge t, i.e. the contents before any write committing on that same edge.
  - Qx = beat0 and QVLDx = 1 during the cycle after edge t+RL; Qx = beat1 and QVLDx = 1 during the cycle after edge t+RL+1.
  - Outside valid beats, Qx = 0 and QVLDx = 0.
- Collision: if both ports commit writes to the same address on the same edge, port B's data wins.
- Read/write overlap: a read sees a write only if the write committed on an edge strictly before the read's command edge.
- Pipelines: in-flight operations are tracked by shift registers of depth RL+1 and WL+1 per port. Up to ceil(RL/2)+1 reads may be outstanding per port.
- Reset mid-operation: all in-flight reads and writes are discarded and QVLD drops on the next cycle. Writes not yet committed do not modify memory.
- Ports are fully independent apart from the shared array and the collision rule. The memory is modelled as two-write, two-read per cycle.

Test Plan:
- Port A writes addr 0x005 with DA beats 0x123456789 then 0xABCDEF012 at t+5 and t+6; port A reads 0x005 at t+10 → QVLDA high during the cycles after edges t+18 and t+19; QA = 0x123456789, then 0xABCDEF012.
- Latency check: a read on port B at edge t → QVLDB low through edge t+7, high exactly two cycles, low again.
- Bad parity: AA = 0x001, APA = 0 → command dropped, PE_n = 0 and stays 0; the following correct-parity commands still work; RST restores PE_n = 1.
- Back-to-back: port A commands at consecutive edges t and t+1 → only the first executes; exactly 2 QVLDA beats appear.
- Collision: A and B both write addr 0x3FF on the same edge (A: 0x111/0x222, B: 0x333/0x444) → a later read returns 0x333, 0x444.
- RST asserted between a read's command and its data → no QVLD pulse; a pending write to 0x010 leaves the old contents intact; AINV = 1 with AA = 0x3FA accesses word 0x005.
